// File: rtl/switch_monitor_pkg.sv
// Shared display codes and state type for the switch monitor.
package switch_monitor_pkg;

    // hexdigit codes above 15 select symbols rather than hex digits
    localparam logic [4:0] HEX_ALLON = 5'd16;
    localparam logic [4:0] HEX_MINUS = 5'd17;
    localparam logic [4:0] HEX_UNDER = 5'd18;
    localparam logic [4:0] HEX_S     = 5'd19;
    localparam logic [4:0] HEX_OFF   = 5'd20;
    localparam logic [4:0] HEX_A     = 5'h0a;

    typedef enum logic [1:0] {BLANK, SHOW, ALL} disp_state_t;

endpackage

// File: rtl/switch_monitor_if.sv
// Switch/LED/7-seg signal bundle; the monitor is the slave, the board side the master.
interface switch_monitor_if #(
    parameter int NSW   = 4,
    parameter int CNT_W = 8
);
    logic [NSW-1:0]   prswi;
    logic [NSW-1:0]   prled;
    logic             sw_evt;
    logic [CNT_W-1:0] evt_cnt;
    logic [7:0]       prhex0;
    logic [7:0]       prhex1;

    modport master (output prswi, input prled, sw_evt, evt_cnt, prhex0, prhex1);
    modport slave  (input prswi, output prled, sw_evt, evt_cnt, prhex0, prhex1);
endinterface

// File: rtl/hexdigit.sv
// 7-segment decoder: o_seg = {dp, g, f, e, d, c, b, a}, 1 = segment lit.
module hexdigit
    import switch_monitor_pkg::*;
(
    input  logic [4:0] i_in,
    input  logic       i_dp,
    output logic [7:0] o_seg
);
    logic [6:0] w_seg;

    always_comb begin
        w_seg = 7'h00;
        case (i_in)
            5'h00:     w_seg = 7'h3f;
            5'h01:     w_seg = 7'h06;
            5'h02:     w_seg = 7'h5b;
            5'h03:     w_seg = 7'h4f;
            5'h04:     w_seg = 7'h66;
            5'h05:     w_seg = 7'h6d;
            5'h06:     w_seg = 7'h7d;
            5'h07:     w_seg = 7'h07;
            5'h08:     w_seg = 7'h7f;
            5'h09:     w_seg = 7'h6f;
            5'h0a:     w_seg = 7'h77;
            5'h0b:     w_seg = 7'h7c;
            5'h0c:     w_seg = 7'h39;
            5'h0d:     w_seg = 7'h5e;
            5'h0e:     w_seg = 7'h79;
            5'h0f:     w_seg = 7'h71;
            HEX_ALLON: w_seg = 7'h7f;
            HEX_MINUS: w_seg = 7'h40;
            HEX_UNDER: w_seg = 7'h08;
            HEX_S:     w_seg = 7'h6d;
            HEX_OFF:   w_seg = 7'h00;
            default:   w_seg = 7'h00;
        endcase
    end

    assign o_seg = {i_dp, w_seg};
endmodule

// File: rtl/switch_monitor_debounce.sv
// One switch channel: two-flop synchroniser followed by a stable-level counter.
module sw_debounce #(
    parameter int DEB_CYC = 250000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_sw,
    output logic o_db
);
    localparam int CW = $clog2(DEB_CYC + 1);

    logic          r_sync1;
    logic          r_sync2;
    logic          r_db;
    logic [CW-1:0] r_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
            r_db    <= 1'b0;
            r_cnt   <= '0;
        end else begin
            r_sync1 <= i_sw;
            r_sync2 <= r_sync1;
            // flip only after DEB_CYC counted disagreements plus one more
            if (r_sync2 == r_db) begin
                r_cnt <= '0;
            end else if (r_cnt == CW'(DEB_CYC)) begin
                r_db  <= ~r_db;
                r_cnt <= '0;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    assign o_db = r_db;
endmodule

// File: rtl/switch_monitor.sv
// Debounced switch bank with LED mirror, event counter and a two-digit
// status display (last changed switch, all-on, or blank after a hold time).
module switch_monitor
    import switch_monitor_pkg::*;
#(
    parameter int NSW      = 4,
    parameter int DEB_CYC  = 250000,
    parameter int HOLD_CYC = 50000000,
    parameter int CNT_W    = 8
) (
    input  logic           clk,
    input  logic           rst_n,
    switch_monitor_if.slave bus
);
    localparam int HW = $clog2(HOLD_CYC + 1);

    if (NSW < 1 || NSW > 16) begin : g_bad_nsw
        $error("switch_monitor: NSW must be in 1..16");
    end

    logic [NSW-1:0]   w_db;
    logic [NSW-1:0]   r_db_d1;
    logic [NSW-1:0]   w_chg;
    logic             w_any_chg;
    logic             w_all_on;
    logic             r_evt;
    logic [CNT_W-1:0] r_evt_cnt;
    disp_state_t      r_state;
    disp_state_t      w_state_next;
    logic [HW-1:0]    r_hold;
    logic [HW-1:0]    w_hold_next;
    logic [4:0]       r_data1;
    logic [4:0]       r_data0;
    logic [4:0]       w_data1_next;
    logic [4:0]       w_data0_next;
    logic [3:0]       w_lo_idx;
    logic             w_lo_val;
    logic [3:0]       w_lo_off;

    for (genvar gi = 0; gi < NSW; gi++) begin : g_deb
        sw_debounce #(.DEB_CYC(DEB_CYC)) u_deb (
            .clk   (clk),
            .rst_n (rst_n),
            .i_sw  (bus.prswi[gi]),
            .o_db  (w_db[gi])
        );
    end

    assign w_chg     = w_db ^ r_db_d1;
    assign w_any_chg = |w_chg;
    assign w_all_on  = &w_db;

    // lowest changed channel wins; w_lo_off names the lowest channel that is off
    always_comb begin
        w_lo_idx = 4'd0;
        w_lo_val = 1'b0;
        w_lo_off = 4'd0;
        for (int k = NSW - 1; k >= 0; k--) begin
            if (w_chg[k]) begin
                w_lo_idx = 4'(k);
                w_lo_val = w_db[k];
            end
            if (!w_db[k]) begin
                w_lo_off = 4'(k);
            end
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_hold_next  = r_hold;
        w_data1_next = r_data1;
        w_data0_next = r_data0;
        if (w_all_on) begin
            w_state_next = ALL;
            w_data1_next = HEX_S;
            w_data0_next = HEX_A;
        end else if (w_any_chg) begin
            w_state_next = SHOW;
            w_hold_next  = HW'(HOLD_CYC);
            w_data1_next = w_lo_val ? HEX_S : HEX_MINUS;
            w_data0_next = {1'b0, w_lo_idx};
        end else if (r_state == SHOW) begin
            if (r_hold <= HW'(1)) begin
                w_state_next = BLANK;
                w_hold_next  = '0;
                w_data1_next = HEX_OFF;
                w_data0_next = HEX_OFF;
            end else begin
                w_hold_next = r_hold - 1'b1;
            end
        end else if (r_state == ALL) begin
            w_state_next = SHOW;
            w_hold_next  = HW'(HOLD_CYC);
            w_data1_next = HEX_MINUS;
            w_data0_next = {1'b0, w_lo_off};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_db_d1   <= '0;
            r_evt     <= 1'b0;
            r_evt_cnt <= '0;
            r_state   <= BLANK;
            r_hold    <= '0;
            r_data1   <= HEX_OFF;
            r_data0   <= HEX_OFF;
        end else begin
            r_db_d1 <= w_db;
            r_evt   <= w_any_chg;
            if (w_any_chg) begin
                r_evt_cnt <= r_evt_cnt + 1'b1;
            end
            r_state <= w_state_next;
            r_hold  <= w_hold_next;
            r_data1 <= w_data1_next;
            r_data0 <= w_data0_next;
        end
    end

    assign bus.prled   = w_db;
    assign bus.sw_evt  = r_evt;
    assign bus.evt_cnt = r_evt_cnt;

    hexdigit u_hex0 (
        .i_in  (r_data0),
        .i_dp  (|w_db),
        .o_seg (bus.prhex0)
    );

    hexdigit u_hex1 (
        .i_in  (r_data1),
        .i_dp  (1'b0),
        .o_seg (bus.prhex1)
    );
endmodule

// File: tb/tb_switch_monitor.sv
// Bench for switch_monitor: directed scenarios plus random switch activity,
// every cycle compared against a window-based behavioural model.
module tb_switch_monitor;
    import switch_monitor_pkg::*;

    localparam int NSW  = 4;
    localparam int DEB  = 4;
    localparam int HOLD = 20;
    localparam int CW   = 8;

    logic           clk   = 1'b0;
    logic           rst_n = 1'b0;
    logic [NSW-1:0] sw    = '0;

    always #5 clk = ~clk;

    switch_monitor_if #(.NSW(NSW), .CNT_W(CW)) bus ();
    assign bus.prswi = sw;

    switch_monitor #(
        .NSW      (NSW),
        .DEB_CYC  (DEB),
        .HOLD_CYC (HOLD),
        .CNT_W    (CW)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // model: a clean level flips once the last DEB+1 samples seen by the
    // second sync flop all disagree with it
    logic [NSW-1:0] samp_q[$];
    logic [NSW-1:0] m_db;
    logic [NSW-1:0] m_chg_prev;
    logic           m_evt;
    logic [CW-1:0]  m_cnt;
    int             m_mode;      // 0 blank, 1 showing a switch, 2 all on
    logic [4:0]     m_code1;
    logic [4:0]     m_code0;
    int             m_edge;
    int             m_evt_edge;
    int             vectors     = 0;
    int             miscompares = 0;

    function automatic logic [6:0] seg7(input logic [4:0] c);
        case (c)
            5'd0:  return 7'h3f;  5'd1:  return 7'h06;  5'd2:  return 7'h5b;
            5'd3:  return 7'h4f;  5'd4:  return 7'h66;  5'd5:  return 7'h6d;
            5'd6:  return 7'h7d;  5'd7:  return 7'h07;  5'd8:  return 7'h7f;
            5'd9:  return 7'h6f;  5'd10: return 7'h77;  5'd11: return 7'h7c;
            5'd12: return 7'h39;  5'd13: return 7'h5e;  5'd14: return 7'h79;
            5'd15: return 7'h71;  5'd16: return 7'h7f;  5'd17: return 7'h40;
            5'd18: return 7'h08;  5'd19: return 7'h6d;
            default: return 7'h00;
        endcase
    endfunction

    task automatic model_reset();
        samp_q.delete();
        repeat (DEB + 3) samp_q.push_back('0);
        m_db       = '0;
        m_chg_prev = '0;
        m_evt      = 1'b0;
        m_cnt      = '0;
        m_mode     = 0;
        m_code1    = 5'd20;
        m_code0    = 5'd20;
        m_edge     = 0;
        m_evt_edge = 0;
    endtask

    task automatic model_edge();
        logic [NSW-1:0] next_db;
        int             sz;
        bit             all_diff;
        int             idx;
        m_edge++;
        samp_q.push_back(sw);
        if (samp_q.size() > 64) void'(samp_q.pop_front());
        sz      = samp_q.size();
        next_db = m_db;
        for (int i = 0; i < NSW; i++) begin
            all_diff = 1'b1;
            for (int j = sz - 3 - DEB; j <= sz - 3; j++)
                if (samp_q[j][i] == m_db[i]) all_diff = 1'b0;
            if (all_diff) next_db[i] = ~m_db[i];
        end
        m_evt = (m_chg_prev != '0);
        if (m_evt) m_cnt = m_cnt + 1'b1;
        if (&m_db) begin
            m_mode  = 2;
            m_code1 = 5'd19;
            m_code0 = 5'd10;
        end else if (m_evt) begin
            idx = 0;
            for (int k = NSW - 1; k >= 0; k--) if (m_chg_prev[k]) idx = k;
            m_mode     = 1;
            m_code1    = m_db[idx] ? 5'd19 : 5'd17;
            m_code0    = 5'(idx);
            m_evt_edge = m_edge;
        end else if (m_mode == 1 && (m_edge - m_evt_edge) >= HOLD) begin
            m_mode  = 0;
            m_code1 = 5'd20;
            m_code0 = 5'd20;
        end else if (m_mode == 2) begin
            idx = 0;
            for (int k = NSW - 1; k >= 0; k--) if (!m_db[k]) idx = k;
            m_mode     = 1;
            m_code1    = 5'd17;
            m_code0    = 5'(idx);
            m_evt_edge = m_edge;
        end
        m_chg_prev = next_db ^ m_db;
        m_db       = next_db;
    endtask

    task automatic cmp(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        assert (got === exp) else begin
            miscompares++;
            $error("FAIL %s edge=%0d got=%0h exp=%0h", tag, m_edge, got, exp);
        end
    endtask

    task automatic check_all();
        cmp("prled",   32'(bus.prled),   32'(m_db));
        cmp("sw_evt",  32'(bus.sw_evt),  32'(m_evt));
        cmp("evt_cnt", 32'(bus.evt_cnt), 32'(m_cnt));
        cmp("prhex0",  32'(bus.prhex0),  32'({|m_db, seg7(m_code0)}));
        cmp("prhex1",  32'(bus.prhex1),  32'({1'b0, seg7(m_code1)}));
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            if (rst_n) model_edge();
            @(negedge clk);
            check_all();
        end
    endtask

    task automatic measure_latency(input int bit_idx, input logic level, input string tag);
        int lat = 0;
        do begin
            tick(1);
            lat++;
        end while (bus.prled[bit_idx] !== level && lat < 20);
        cmp(tag, 32'(lat), 32'(DEB + 3));
    endtask

    task automatic async_reset(input string tag);
        #2 rst_n = 1'b0;
        model_reset();
        #1;
        cmp({tag, "_prled"},   32'(bus.prled),   32'h0);
        cmp({tag, "_evt_cnt"}, 32'(bus.evt_cnt), 32'h0);
        cmp({tag, "_sw_evt"},  32'(bus.sw_evt),  32'h0);
        cmp({tag, "_hex0"},    32'(bus.prhex0),  32'h0);
        cmp({tag, "_hex1"},    32'(bus.prhex1),  32'h0);
        @(negedge clk);
        check_all();
    endtask

    initial begin
        model_reset();

        // 1: reset held while switches toggle, then released
        @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            sw = 4'(i * 5 + 3);
            tick(1);
        end
        cmp("rst_hex1", 32'(bus.prhex1), 32'h0);
        cmp("rst_hex0", 32'(bus.prhex0), 32'h0);
        sw    = '0;
        rst_n = 1'b1;
        tick(3);
        cmp("post_rst_hex1", 32'(bus.prhex1), 32'h0);

        // 2: single switch on, exact latency, display S2, then timeout to blank
        sw = 4'b0100;
        measure_latency(2, 1'b1, "lat_sw2");
        tick(1);
        cmp("t2_sw_evt", 32'(bus.sw_evt), 32'h1);
        cmp("t2_hex1",   32'(bus.prhex1), 32'(7'h6d));
        cmp("t2_hex0",   32'(bus.prhex0), 32'({1'b1, 7'h5b}));
        tick(2);
        cmp("t2_evt_cnt", 32'(bus.evt_cnt), 32'h1);
        tick(HOLD);
        cmp("t2_blank1", 32'(bus.prhex1), 32'h0);
        cmp("t2_blank0", 32'(bus.prhex0), 32'h80);

        // 3: bouncing switch 1 never accepted
        repeat (5) begin
            sw[1] = 1'b1;
            tick(3);
            sw[1] = 1'b0;
            tick(3);
        end
        tick(DEB + 4);
        cmp("t3_prled",   32'(bus.prled),   32'h4);
        cmp("t3_evt_cnt", 32'(bus.evt_cnt), 32'h1);

        // 4: all off, then all on in one cycle, then drop switch 3
        sw = 4'b0000;
        tick(DEB + 6);
        sw = 4'b1111;
        tick(DEB + 4);
        cmp("t4_all_hex1", 32'(bus.prhex1), 32'(7'h6d));
        cmp("t4_all_hex0", 32'(bus.prhex0), 32'({1'b1, 7'h77}));
        cmp("t4_evt_cnt",  32'(bus.evt_cnt), 32'h3);
        sw[3] = 1'b0;
        tick(DEB + 5);
        cmp("t4_drop_hex1", 32'(bus.prhex1), 32'(7'h40));
        cmp("t4_drop_hex0", 32'(bus.prhex0), 32'({1'b1, 7'h4f}));

        // 5: switches 0 and 3 drop together, lowest index shown
        sw = 4'b1001;
        tick(DEB + 6);
        sw = 4'b0000;
        tick(DEB + 4);
        cmp("t5_hex1",    32'(bus.prhex1),  32'(7'h40));
        cmp("t5_hex0",    32'(bus.prhex0),  32'({1'b0, 7'h3f}));
        cmp("t5_evt_cnt", 32'(bus.evt_cnt), 32'(m_cnt));

        // 6: reset mid-debounce and mid-show, pending level re-debounces fully
        sw = 4'b0110;
        tick(3);
        async_reset("t6a");
        rst_n = 1'b1;
        measure_latency(1, 1'b1, "lat_t6a");
        tick(5);
        async_reset("t6b");
        rst_n = 1'b1;
        measure_latency(2, 1'b1, "lat_t6b");
        tick(3);

        // random switch activity with occasional short glitches
        for (int r = 0; r < 60; r++) begin
            sw = 4'($urandom_range(0, 15));
            tick($urandom_range(1, 10));
        end

        // long toggle run to take the event counter through its wrap
        for (int r = 0; r < 260; r++) begin
            sw[0] = ~sw[0];
            tick(DEB + 2);
        end
        tick(HOLD + 2);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
